// File: rtl/tdes_pass_sequencer.sv
// rtl/tdes_pass_sequencer.sv - Triple-DES pass sequencer around a shared single-DES engine
//
// Runs three DES passes per 64-bit block: EDE (key1,key2,key3) when encrypting,
// DED (key3,key2,key1) when decrypting. A block is taken from the receive side,
// sequenced through the engine, then held for the transmit side until acked.
//
// Optional feature macro: TDES_TIMEOUT_EN (per-pass des_done timeout, timeout_err port,
// TIMEOUT_CYCLES parameter).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rcv_data_ready, rcv_data      receive strobe and block
//   encrypt                       asynchronous mode level (1 = encrypt)
//   key1, key2, key3              DES keys
//   handshake_ack                 transmit side consumed trans_data
//   trans_data, trans_data_ready  result block and its valid flag
//   busy                          high whenever not idle
//   des_start, des_mode, des_key, des_din   engine pass launch and operands
//   des_done, des_dout            engine completion strobe and result
//   timeout_err                   sticky abort flag (TDES_TIMEOUT_EN only)

module tdes_pass_sequencer
`ifdef TDES_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rcv_data_ready,
    input  logic [63:0] rcv_data,
    input  logic        encrypt,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic        handshake_ack,
    output logic [63:0] trans_data,
    output logic        trans_data_ready,
    output logic        busy,
    output logic        des_start,
    output logic        des_mode,
    output logic [63:0] des_key,
    output logic [63:0] des_din,
    input  logic        des_done,
    input  logic [63:0] des_dout
`ifdef TDES_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [63:0] blk_q, blk_d;
    logic        mode_q, mode_d;
    logic        enc_s1_q, enc_s2_q;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

`ifdef TDES_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        blk_d   = blk_q;
        mode_d  = mode_q;
`ifdef TDES_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rcv_data_ready) begin
                    blk_d   = rcv_data;
                    mode_d  = enc_s2_q;
                    pass_d  = 2'd0;
                    state_d = S_ISSUE;
`ifdef TDES_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef TDES_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (des_done) begin
                    blk_d = des_dout;
                    if (pass_q == 2'd2) begin
                        state_d = S_HOLD;
                    end else begin
                        pass_d  = pass_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
`ifdef TDES_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                // A receive strobe coinciding with the ack is dropped, not queued.
                if (handshake_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobe/flag outputs are registered from the next state so they line up with it.
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pass_q   <= 2'd0;
            blk_q    <= 64'd0;
            mode_q   <= 1'b0;
            enc_s1_q <= 1'b0;
            enc_s2_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef TDES_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            blk_q    <= blk_d;
            mode_q   <= mode_d;
            enc_s1_q <= encrypt;
            enc_s2_q <= enc_s1_q;
            start_q  <= start_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
`ifdef TDES_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Pass schedule: encrypt E/D/E with key1/key2/key3, decrypt D/E/D with key3/key2/key1.
    always_comb begin
        des_mode = mode_q ? (pass_q != 2'd1) : (pass_q == 2'd1);
        case (pass_q)
            2'd0:    des_key = mode_q ? key1 : key3;
            2'd1:    des_key = key2;
            default: des_key = mode_q ? key3 : key1;
        endcase
    end

    assign des_din          = blk_q;
    assign trans_data       = blk_q;
    assign des_start        = start_q;
    assign busy             = busy_q;
    assign trans_data_ready = ready_q;
`ifdef TDES_TIMEOUT_EN
    assign timeout_err      = err_q;
`endif

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// tb/tb_tdes_pass_sequencer.sv - directed self-checking bench for tdes_pass_sequencer

module tb_tdes_pass_sequencer;

    localparam logic [63:0] K1 = 64'hCA3A3E989AA7AE58;
    localparam logic [63:0] K2 = 64'hEB806D4E20A6C744;
    localparam logic [63:0] K3 = 64'h21735514632D155D;
    localparam logic [63:0] PT = 64'h9999999999999999;
    localparam logic [63:0] I1 = 64'h7f733851c5f235d9;
    localparam logic [63:0] I2 = 64'h6ca7c3f173252118;
    localparam logic [63:0] CT = 64'hb533f124beb485ec;

    logic        clk;
    logic        rst;
    logic        rcv_data_ready;
    logic [63:0] rcv_data;
    logic        encrypt;
    logic [63:0] key1, key2, key3;
    logic        handshake_ack;
    logic [63:0] trans_data;
    logic        trans_data_ready;
    logic        busy;
    logic        des_start;
    logic        des_mode;
    logic [63:0] des_key;
    logic [63:0] des_din;
    logic        des_done;
    logic [63:0] des_dout;
`ifdef TDES_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_key  [3];
    logic        exp_mode [3];
    logic [63:0] exp_din  [3];
    logic [63:0] eng_dout [3];

    tdes_pass_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .rcv_data_ready   (rcv_data_ready),
        .rcv_data         (rcv_data),
        .encrypt          (encrypt),
        .key1             (key1),
        .key2             (key2),
        .key3             (key3),
        .handshake_ack    (handshake_ack),
        .trans_data       (trans_data),
        .trans_data_ready (trans_data_ready),
        .busy             (busy),
        .des_start        (des_start),
        .des_mode         (des_mode),
        .des_key          (des_key),
        .des_din          (des_din),
        .des_done         (des_done),
        .des_dout         (des_dout)
`ifdef TDES_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_encrypt_sched();
        exp_key  = '{K1, K2, K3};
        exp_mode = '{1'b1, 1'b0, 1'b1};
        exp_din  = '{PT, I1, I2};
        eng_dout = '{I1, I2, CT};
    endtask

    task automatic set_decrypt_sched();
        exp_key  = '{K3, K2, K1};
        exp_mode = '{1'b0, 1'b1, 1'b0};
        exp_din  = '{CT, I2, I1};
        eng_dout = '{I2, I1, PT};
    endtask

    // Cycle k is the clock period ending at edge k; the accept edge ends cycle 0.
    task automatic run_block(input logic [63:0] blk, input int n, input logic flip_enc,
                             input string tag);
        int cyc;
        int bud;
        rcv_data       = blk;
        rcv_data_ready = 1'b1;
        tick();
        rcv_data_ready = 1'b0;
        if (flip_enc) encrypt = ~encrypt;
        cyc = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
        end
        for (int p = 0; p < 3; p++) begin
            bud = 0;
            while (des_start !== 1'b1 && bud < 200) begin
                tick();
                cyc++;
                bud++;
            end
            checks++;
            if (des_start !== 1'b1 || cyc != 1 + p * (n + 1)) begin
                errors++;
                $display("FAIL %s start_p%0d: got start=%b cyc=%0d want start=1 cyc=%0d",
                         tag, p, des_start, cyc, 1 + p * (n + 1));
            end
            checks++;
            if (des_key !== exp_key[p] || des_mode !== exp_mode[p] || des_din !== exp_din[p]) begin
                errors++;
                $display("FAIL %s operands_p%0d: got key=%h mode=%b din=%h want key=%h mode=%b din=%h",
                         tag, p, des_key, des_mode, des_din, exp_key[p], exp_mode[p], exp_din[p]);
            end
            repeat (n) begin
                tick();
                cyc++;
            end
            if (p == 2) begin
                checks++;
                if (trans_data_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_ready: got %b want 0", tag, trans_data_ready);
                end
            end
            des_done = 1'b1;
            des_dout = eng_dout[p];
            tick();
            cyc++;
            des_done = 1'b0;
            des_dout = 64'd0;
        end
        checks++;
        if (trans_data_ready !== 1'b1 || cyc != 3 * n + 4 || trans_data !== eng_dout[2]) begin
            errors++;
            $display("FAIL %s result: got ready=%b cyc=%0d data=%h want ready=1 cyc=%0d data=%h",
                     tag, trans_data_ready, cyc, trans_data, 3 * n + 4, eng_dout[2]);
        end
    endtask

    task automatic do_ack(input string tag);
        handshake_ack = 1'b1;
        tick();
        handshake_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || trans_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_idle: got busy=%b ready=%b want 0 0", tag, busy, trans_data_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (trans_data !== 64'd0 || trans_data_ready !== 1'b0 || busy !== 1'b0 ||
            des_start !== 1'b0 || des_mode !== 1'b0 || des_din !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h ready=%b busy=%b start=%b mode=%b din=%h want all 0",
                     trans_data, trans_data_ready, busy, des_start, des_mode, des_din);
        end
    endtask

    task automatic test_encrypt();
        encrypt = 1'b1;
        tick();
        tick();
        set_encrypt_sched();
        run_block(PT, 16, 1'b0, "encrypt");
        do_ack("encrypt");
    endtask

    task automatic test_decrypt();
        encrypt = 1'b0;
        tick();
        tick();
        set_decrypt_sched();
        run_block(CT, 16, 1'b0, "decrypt");
        do_ack("decrypt");
    endtask

    task automatic test_back_pressure();
        encrypt = 1'b1;
        tick();
        tick();
        set_encrypt_sched();
        // encrypt is flipped right after acceptance; the schedule must stay EDE
        run_block(PT, 3, 1'b1, "backpressure");
        for (int i = 0; i < 20; i++) begin
            rcv_data       = 64'h0123456789abcdef;
            rcv_data_ready = (i == 5 || i == 12);
            tick();
            rcv_data_ready = 1'b0;
            checks++;
            if (trans_data !== CT || trans_data_ready !== 1'b1 || des_start !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable_%0d: got data=%h ready=%b start=%b want data=%h ready=1 start=0",
                         i, trans_data, trans_data_ready, des_start, CT);
            end
        end
        handshake_ack  = 1'b1;
        rcv_data_ready = 1'b1;
        tick();
        handshake_ack  = 1'b0;
        rcv_data_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || trans_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL ack_with_req: got busy=%b ready=%b want 0 0", busy, trans_data_ready);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || des_start !== 1'b0) begin
            errors++;
            $display("FAIL req_dropped: got busy=%b start=%b want 0 0", busy, des_start);
        end
    endtask

    task automatic test_reset_mid_pass();
        encrypt = 1'b1;
        tick();
        tick();
        rcv_data       = PT;
        rcv_data_ready = 1'b1;
        tick();
        rcv_data_ready = 1'b0;
        // cycle 1: ISSUE pass 0; respond after 4 cycles
        repeat (4) tick();
        des_done = 1'b1;
        des_dout = I1;
        tick();
        des_done = 1'b0;
        des_dout = 64'd0;
        // ISSUE of pass 1, then into WAIT
        tick();
        checks++;
        if (busy !== 1'b1 || des_din !== I1) begin
            errors++;
            $display("FAIL midpass_setup: got busy=%b din=%h want 1 %h", busy, des_din, I1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (trans_data !== 64'd0 || trans_data_ready !== 1'b0 || busy !== 1'b0 ||
            des_start !== 1'b0 || des_mode !== 1'b0) begin
            errors++;
            $display("FAIL midpass_reset: got data=%h ready=%b busy=%b start=%b mode=%b want all 0",
                     trans_data, trans_data_ready, busy, des_start, des_mode);
        end
        des_done = 1'b1;
        des_dout = I2;
        tick();
        des_done = 1'b0;
        des_dout = 64'd0;
        tick();
        checks++;
        if (busy !== 1'b0 || trans_data !== 64'd0 || des_start !== 1'b0 || trans_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL late_done_ignored: got busy=%b data=%h start=%b ready=%b want 0 0 0 0",
                     busy, trans_data, des_start, trans_data_ready);
        end
        encrypt = 1'b0;
        tick();
        tick();
        set_decrypt_sched();
        run_block(CT, 2, 1'b0, "after_reset");
        do_ack("after_reset");
    endtask

`ifdef TDES_TIMEOUT_EN
    task automatic test_timeout();
        encrypt = 1'b1;
        tick();
        tick();
        rcv_data       = PT;
        rcv_data_ready = 1'b1;
        tick();
        rcv_data_ready = 1'b0;
        checks++;
        if (des_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start: got %b want 1", des_start);
        end
        repeat (64) tick();
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got busy=%b err=%b want 1 0", busy, timeout_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || trans_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got busy=%b err=%b ready=%b want 0 1 0",
                     busy, timeout_err, trans_data_ready);
        end
        repeat (3) tick();
        checks++;
        if (timeout_err !== 1'b1 || trans_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b ready=%b want 1 0", timeout_err, trans_data_ready);
        end
        set_encrypt_sched();
        run_block(PT, 5, 1'b0, "post_timeout");
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b want 0", timeout_err);
        end
        do_ack("post_timeout");
    endtask
`endif

    initial begin
        rst            = 1'b1;
        rcv_data_ready = 1'b0;
        rcv_data       = 64'd0;
        encrypt        = 1'b0;
        key1           = K1;
        key2           = K2;
        key3           = K3;
        handshake_ack  = 1'b0;
        des_done       = 1'b0;
        des_dout       = 64'd0;

        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_pressure();
        test_reset_mid_pass();
`ifdef TDES_TIMEOUT_EN
        test_timeout();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdes_pass_sequencer.md
# tdes_pass_sequencer

Controller that runs a single-DES engine three times per 64-bit block to implement Triple-DES (EDE encrypt / DED decrypt) for the USB encryptor datapath. It accepts a block from the receive side, issues three key/mode-sequenced passes to the shared DES engine, and holds the result for the transmit side until acknowledged. It sits between the USB receive buffer and the transmit packer, wrapping the DES round engine.

## Interface
- TIMEOUT_CYCLES, 64, cycles allowed per pass for `des_done` before abort; only used with `TDES_TIMEOUT_EN`
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rcv_data_ready  in  1  one-cycle strobe: `rcv_data` is valid
- rcv_data  in  64  plaintext or ciphertext block
- encrypt  in  1  asynchronous mode level (1 = encrypt, 0 = decrypt); two-flop synchronized internally
- key1, key2, key3  in  64 each  DES keys; parity bits passed through unused
- handshake_ack  in  1  transmit side has consumed `trans_data`
- trans_data  out  64  result block
- trans_data_ready  out  1  `trans_data` valid, held until ack
- busy  out  1  high in every state except IDLE
- des_start  out  1  one-cycle pass launch to engine
- des_mode  out  1  1 = encrypt pass, 0 = decrypt pass
- des_key  out  64  key for current pass
- des_din  out  64  input block for current pass
- des_done  in  1  engine result valid, one-cycle strobe
- des_dout  in  64  engine result
- timeout_err  out  1  sticky abort flag; exists only with `TDES_TIMEOUT_EN`

## Operation
- States: IDLE, ISSUE, WAIT, HOLD. 2-bit pass counter `pass` (0..2). 64-bit block register `blk`. Latched mode `mode_q`.
- IDLE: on `rcv_data_ready`=1, `blk` <= `rcv_data`, `mode_q` <= synchronized `encrypt`, `pass` <= 0, go ISSUE. `encrypt` changes after acceptance have no effect on the block in flight.
- ISSUE: `des_start`=1 for exactly this cycle; go WAIT.
- WAIT: on `des_done`=1, `blk` <= `des_dout`; if `pass`==2 go HOLD, else `pass`++ and go ISSUE.
- HOLD: `trans_data_ready`=1; on `handshake_ack`=1 go IDLE.
- Pass schedule, encrypt: (key1, E), (key2, D), (key3, E). Decrypt: (key3, D), (key2, E), (key1, D).
- `des_din` = `blk`, `des_key`/`des_mode` = schedule entry for `pass`; held stable through ISSUE and WAIT.
- `trans_data` = `blk` continuously; meaningful only while `trans_data_ready`=1.
- `rcv_data_ready` outside IDLE is ignored (no queuing). `des_done` outside WAIT is ignored.
- HOLD with `handshake_ack` and `rcv_data_ready` both high: ack taken, request dropped; sender must re-present in IDLE.
- Key inputs are sampled live each pass; they must stay stable while `busy`=1.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `pass`=0, `blk`=0, `mode_q`=0, sync flops 0, all outputs 0 (`trans_data`=0, `trans_data_ready`=0, `busy`=0, `des_start`=0, `des_mode`=0, `des_key`=0 is not required — `des_key` reflects key3/key1 mux and is don't-care while `busy`=0). Reset in any state aborts the block; no output strobe follows.
- Outputs are Moore (functions of registered state), no combinational input-to-output paths except `des_key`/`des_din` muxes on registered selects.
- If engine asserts `des_done` N≥1 cycles after `des_start`, each pass takes N+1 cycles. Accept edge = cycle 0; first `des_start` in cycle 1; `trans_data_ready` rises in cycle 3N+4.
- `des_done` in the same cycle as `des_start` (N=0) is not supported.
- Mode sync latency: `encrypt` change must precede `rcv_data_ready` by ≥2 cycles to apply.

## Configuration
- `TDES_TIMEOUT_EN` defined: per-pass counter cleared in ISSUE, counts in WAIT; reaching TIMEOUT_CYCLES without `des_done` sets `timeout_err`=1, returns to IDLE, no `trans_data_ready`. `timeout_err` clears only on reset or next accepted block.
- Undefined: no counter, no `timeout_err` port; WAIT waits indefinitely.

## Test plan
- Encrypt: `encrypt`=1, keys CA3A3E989AA7AE58 / EB806D4E20A6C744 / 21735514632D155D, `rcv_data`=9999999999999999, DES model N=16 -> `des_dout` sequence 7f733851c5f235d9, 6ca7c3f173252118, b533f124beb485ec; `trans_data`=b533f124beb485ec, `trans_data_ready` at cycle 52.
- Decrypt: `encrypt`=0, same keys, `rcv_data`=b533f124beb485ec -> passes key3/D, key2/E, key1/D; `trans_data`=9999999999999999.
- Backpressure: hold `handshake_ack`=0 for 20 cycles in HOLD, pulse `rcv_data_ready` meanwhile -> `trans_data` stable, request ignored, one `des_start` train only; ack returns IDLE next cycle, `busy`=0.
- Reset mid-pass: assert `rst` during WAIT of pass 1 -> next cycle all outputs 0, state IDLE; late `des_done` ignored; subsequent block completes correctly.
- Timeout (`TDES_TIMEOUT_EN`, TIMEOUT_CYCLES=64): engine never responds -> `timeout_err`=1 after 64 WAIT cycles, `busy`=0, `trans_data_ready` never asserts; next accepted block clears `timeout_err`.
